// File: rtl/fft_pkg.sv
// Shared types for the FFT frame sequencer.
//   fft_seq_state_t : sequencer FSM states
//   fft_len(m)      : FFT length N = 2**m
package fft_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_START,
    ST_RUN,
    ST_DRAIN,
    ST_CLEAR
  } fft_seq_state_t;

  function automatic int unsigned fft_len(input int unsigned m);
    return 32'd1 << m;
  endfunction

endpackage

// File: rtl/fft_seq_delay.sv
// RD_LAT-deep shift register that aligns the done-entry pulse with the first
// result word on the FFT core output.
//   clk, reset : clock, asynchronous active-low reset
//   clear      : synchronous flush (frame abandoned)
//   d          : done-entry pulse
//   q          : pulse delayed by RD_LAT cycles
module fft_seq_delay #(
  parameter int unsigned RD_LAT = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic d,
  output logic q
);

  logic [RD_LAT-1:0] pipe;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pipe <= '0;
    end else if (clear) begin
      pipe <= '0;
    end else begin
      pipe[0] <= d;
      for (int unsigned i = 1; i < RD_LAT; i++) begin
        pipe[i] <= pipe[i-1];
      end
    end
  end

  assign q = pipe[RD_LAT-1];

endmodule

// File: rtl/fft_frame_sequencer.sv
// Sequences an FFT core through whole frames: load N samples, start, wait for
// done, drain N results as a counted stream, clear the core, repeat.
//   clk, reset           : clock, asynchronous active-low reset
//   enable, abort        : frame start permission / abandon current frame
//   sample_*             : input sample stream (valid/ready)
//   fft_load/rd_adr/rd   : core write port (combinational in LOAD)
//   fft_start, fft_reset : core control
//   fft_done, fft_wd     : core status and result word
//   out_data/index/valid : result stream, no backpressure; out_ready only
//                          feeds the sticky overrun flag
//   busy, frame_count    : status
module fft_frame_sequencer
  import fft_pkg::*;
#(
  parameter int unsigned width  = 16,
  parameter int unsigned M      = 5,
  parameter int unsigned RD_LAT = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic               abort,
  input  logic [2*width-1:0] sample_data,
  input  logic               sample_valid,
  output logic               sample_ready,
  output logic               fft_load,
  output logic [M-1:0]       fft_rd_adr,
  output logic [2*width-1:0] fft_rd,
  output logic               fft_start,
  output logic               fft_reset,
  input  logic               fft_done,
  input  logic [2*width-1:0] fft_wd,
  output logic [2*width-1:0] out_data,
  output logic [M-1:0]       out_index,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               busy,
  output logic               overrun,
  output logic [15:0]        frame_count
);

  localparam int unsigned N        = fft_len(M);
  localparam logic [M-1:0] CNT_LAST = M'(N - 1);

  fft_seq_state_t state, state_nxt;
  logic [M-1:0]   cnt, cnt_nxt;
  logic           streaming, streaming_nxt;
  logic           overrun_nxt;
  logic [15:0]    frame_count_nxt;
  logic           done_entry, first_beat;
  logic           cnt_last;

  // Word 0 appears RD_LAT cycles after done rises; the delayed entry pulse
  // opens the drain window and 'streaming' holds it open afterwards.
  assign done_entry = (state == ST_RUN) && fft_done && !abort;

  fft_seq_delay #(.RD_LAT(RD_LAT)) u_delay (
    .clk   (clk),
    .reset (reset),
    .clear (abort),
    .d     (done_entry),
    .q     (first_beat)
  );

  assign cnt_last     = (cnt == CNT_LAST);
  assign sample_ready = (state == ST_LOAD) && !abort;
  assign fft_load     = sample_ready && sample_valid;
  assign fft_rd       = (state == ST_LOAD) ? sample_data : '0;
  assign fft_rd_adr   = (state == ST_LOAD) ? cnt : '0;
  assign fft_start    = (state == ST_START);
  assign fft_reset    = (state == ST_IDLE) || (state == ST_CLEAR);
  assign busy         = (state != ST_IDLE);
  assign out_valid    = (state == ST_DRAIN) && (first_beat || streaming);
  assign out_index    = (state == ST_DRAIN) ? cnt : '0;
  assign out_data     = fft_wd;

  always_comb begin
    state_nxt       = state;
    cnt_nxt         = cnt;
    streaming_nxt   = streaming;
    overrun_nxt     = overrun;
    frame_count_nxt = frame_count;

    if (out_valid && !out_ready) overrun_nxt = 1'b1;

    unique case (state)
      ST_IDLE: begin
        if (enable) begin
          state_nxt   = ST_LOAD;
          overrun_nxt = 1'b0;
        end
      end
      ST_LOAD: begin
        if (abort) begin
          state_nxt = ST_CLEAR;
          cnt_nxt   = '0;
        end else if (sample_valid) begin
          if (cnt_last) begin
            state_nxt = ST_START;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end
      end
      ST_START: begin
        state_nxt = abort ? ST_CLEAR : ST_RUN;
        if (abort) cnt_nxt = '0;
      end
      ST_RUN: begin
        if (abort) begin
          state_nxt = ST_CLEAR;
          cnt_nxt   = '0;
        end else if (fft_done) begin
          state_nxt = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (abort) begin
          state_nxt     = ST_CLEAR;
          cnt_nxt       = '0;
          streaming_nxt = 1'b0;
        end else if (out_valid) begin
          if (cnt_last) begin
            state_nxt       = ST_CLEAR;
            cnt_nxt         = '0;
            streaming_nxt   = 1'b0;
            // Counted on the completing beat so aborted frames never count.
            frame_count_nxt = frame_count + 16'd1;
          end else begin
            cnt_nxt       = cnt + 1'b1;
            streaming_nxt = 1'b1;
          end
        end
      end
      ST_CLEAR: begin
        if (enable) begin
          state_nxt   = ST_LOAD;
          overrun_nxt = 1'b0;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      streaming   <= 1'b0;
      overrun     <= 1'b0;
      frame_count <= '0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      streaming   <= streaming_nxt;
      overrun     <= overrun_nxt;
      frame_count <= frame_count_nxt;
    end
  end

endmodule

// File: doc/fft_frame_sequencer.md
# fft_frame_sequencer

Sequences the FFT core through complete frames: streams N = 2^M input samples into the core with a valid/ready handshake, issues the start pulse, waits for completion, drains the N results as a counted output stream, then clears the core for the next frame. Sits between the sample source (ADC/I2S front end) and the `fft` top, driving its `load`, `rd_adr`, `start` and `reset` pins and observing `done`. In continuous mode it repeats frames back-to-back without software involvement.

## Interface
- `width`, 16: sample/result word width (real+imag packed as in the FFT core, 2*width bits)
- `M`, 5: log2 of FFT length; N = 2^M
- `RD_LAT`, 1: cycles from the FFT core's `done` rising to result word 0 valid on its output
- `clk` in 1: the single clock
- `reset` in 1: asynchronous, active-low reset
- `enable` in 1: level; frames start only while high
- `abort` in 1: abandon the current frame
- `sample_data` in 2*width: input sample
- `sample_valid` in 1: sample_data valid
- `sample_ready` out 1: sequencer accepts a sample this cycle
- `fft_load` out 1: to core `load`
- `fft_rd_adr` out M: to core `rd_adr`, natural order; the core bit-reverses
- `fft_rd` out 2*width: to core `rd`
- `fft_start` out 1: to core `start`, one-cycle pulse
- `fft_reset` out 1: to core `reset`, active-high
- `fft_done` in 1: from core `done`
- `fft_wd` in 2*width: from core result output
- `out_data` out 2*width: result word
- `out_index` out M: bin index of out_data
- `out_valid` out 1: result beat
- `out_ready` in 1: sink ready; advisory only, see overrun
- `busy` out 1: state is not IDLE
- `overrun` out 1: sticky; a result beat was presented while out_ready was low
- `frame_count` out 16: completed frames, wraps

## Operation
- States: IDLE, LOAD, START, RUN, DRAIN, CLEAR.
- IDLE: fft_reset=1; goes to LOAD when enable=1. overrun clears on IDLE→LOAD.
- LOAD: sample_ready=1. fft_load = sample_valid. fft_rd = sample_data. fft_rd_adr = cnt.
  - On each accepted beat (valid & ready), cnt increments.
  - On the accept with cnt=N-1: cnt←0 and the state goes to START.
  - Gaps in sample_valid stall loading; no write occurs on those cycles.
- START: fft_start=1 for exactly one cycle, then RUN.
- RUN: wait for fft_done=1, then DRAIN. All core outputs other than fft_start are 0.
- DRAIN: a delay line of RD_LAT stages on the done-entry produces out_valid.
  - out_valid holds for exactly N consecutive cycles. out_data = fft_wd. out_index = cnt, incrementing 0..N-1.
  - No backpressure is possible because the core's output index free-runs. A beat with out_ready=0 sets overrun. The beat is not repeated.
  - After the beat with index N-1, the state goes to CLEAR.
- CLEAR: fft_reset=1 for one cycle. frame_count increments. Then LOAD if enable=1, else IDLE.
- abort=1 in LOAD, START, RUN or DRAIN: next state is CLEAR; cnt←0; out_valid deasserts next cycle; frame_count is not incremented. abort is ignored in IDLE and CLEAR.
- If enable drops mid-frame, the current frame completes, then the state goes to IDLE.

## Timing
- Reset values (async assertion, reset=0):
  - state=IDLE, cnt=0, frame_count=0, overrun=0.
  - fft_reset=1; sample_ready, fft_load, fft_start, out_valid = 0; out_index=0.
- Reset deasserts synchronously to clk. The first LOAD cycle is at the earliest the first edge with enable=1.
- A reset mid-frame discards the frame. The core is held cleared through IDLE's fft_reset.
- Frame latency with zero-gap input: N load + 1 start + the core's M·N/2 compute cycles + RD_LAT + N drain + 1 clear.
- sample_ready, fft_load, fft_rd and fft_rd_adr are combinational from state, cnt and input. All other outputs are registered or state-decoded.
- If abort and the final load beat occur together, abort wins and the beat is discarded. The same applies to abort with the last drain beat: frame_count is not incremented.

## Structure
- Package `fft_pkg` holds the state enum `fft_seq_state_t` and the localparam `N = 2**M` helper.
- One sub-module, `fft_seq_delay`: an RD_LAT-deep shift register aligning done to fft_wd. `cnt` is shared between LOAD and DRAIN.

## Test plan
- Reset then enable=1, 32 samples with valid tied high (M=5):
  - sample_ready is high for exactly 32 cycles.
  - fft_rd_adr runs 0..31.
  - fft_start pulses once, on the cycle after adr 31.
- Load with valid low on every other cycle: 32 writes at addresses 0..31 only; the load phase takes 63 cycles; no extra fft_load pulses.
- Core model raises fft_done (RD_LAT=1):
  - out_valid is high 32 cycles, starting one cycle after done.
  - out_index runs 0..31.
  - fft_reset is high for one cycle afterwards; frame_count=1.
- out_ready=0 on index 7 only: overrun=1 and stays 1; the stream is still 32 beats; overrun clears at the next frame start.
- abort during RUN: CLEAR next cycle, fft_reset pulse, frame_count unchanged, then LOAD restarts at address 0.
- reset asserted at load index 12: all outputs take reset values immediately; after release, loading restarts at address 0.
